// File: rtl/image_loader.sv
// image_loader
//   Assembles a stream of pixels into one full image held in a wide register.
//   The loader accepts pixels while in LOAD. When the last pixel is written, it
//   moves to FULL and holds the image until a consumer handshake. It then
//   returns to LOAD. On that return, old pixel data is left in place and is
//   overwritten by the next image.
//
//   state | meaning
//   LOAD  | accepting pixels (pixel_ready=1, image_valid=0)
//   FULL  | complete image presented (pixel_ready=0, image_valid=1)
//
// Ports
//   clock        sole clock, rising edge
//   reset        asynchronous active-low reset
//   pixel_in     incoming pixel value
//   pixel_first  marks pixel_in as pixel 0 of an image (resynchronises)
//   pixel_valid  pixel_in / pixel_first valid
//   pixel_ready  loader accepts a pixel this cycle
//   image        assembled image, element 0 is the first pixel
//   image_valid  image holds a complete image
//   image_ready  consumer takes the image
//   pixel_count  index of the next pixel to be written
//   checksum     (only with IMAGE_LOADER_CHECKSUM_EN) mod-2^16 sum of the
//                image's pixels, valid while image_valid=1
//
// Optional feature macro: IMAGE_LOADER_CHECKSUM_EN
module image_loader #(
  parameter  int PIXEL_WIDTH = 9,
  parameter  int NUM_PIXELS  = 784,
  localparam int CW          = $clog2(NUM_PIXELS)
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [PIXEL_WIDTH-1:0]                 pixel_in,
  input  logic                                   pixel_first,
  input  logic                                   pixel_valid,
  output logic                                   pixel_ready,
  output logic [0:NUM_PIXELS-1][PIXEL_WIDTH-1:0] image,
  output logic                                   image_valid,
  input  logic                                   image_ready,
  output logic [CW-1:0]                          pixel_count
`ifdef IMAGE_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]                            checksum
`endif
);

  typedef enum logic {LOAD = 1'b0, FULL = 1'b1} state_e;

  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_PIXELS - 1);

  state_e                                 state_q;
  logic                                   pixel_ready_q;
  logic                                   image_valid_q;
  logic [CW-1:0]                          count_q;
  logic [CW-1:0]                          count_d;
  logic [0:NUM_PIXELS-1][PIXEL_WIDTH-1:0] image_q;

  logic          pix_hs;
  logic          img_hs;
  logic [CW-1:0] wr_idx;
  logic          last_pix;

  // pixel_ready_q is only high in LOAD, so a pixel handshake cannot happen in
  // FULL. This also means no pixel is taken in the image handshake cycle.
  assign pix_hs   = pixel_valid & pixel_ready_q;
  assign img_hs   = image_valid_q & image_ready;
  assign wr_idx   = pixel_first ? '0 : count_q;
  assign last_pix = (wr_idx == LAST_IDX);
  assign count_d  = last_pix ? '0 : wr_idx + CW'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= LOAD;
      pixel_ready_q <= 1'b1;
      image_valid_q <= 1'b0;
      count_q       <= '0;
      image_q       <= '0;
    end else if (state_q == LOAD) begin
      if (pix_hs) begin
        image_q[wr_idx] <= pixel_in;
        count_q         <= count_d;
        if (last_pix) begin
          state_q       <= FULL;
          pixel_ready_q <= 1'b0;
          image_valid_q <= 1'b1;
        end
      end
    end else begin
      if (img_hs) begin
        state_q       <= LOAD;
        pixel_ready_q <= 1'b1;
        image_valid_q <= 1'b0;
      end
    end
  end

  assign pixel_ready = pixel_ready_q;
  assign image_valid = image_valid_q;
  assign image       = image_q;
  assign pixel_count = count_q;

`ifdef IMAGE_LOADER_CHECKSUM_EN
  logic [15:0] checksum_q;
  logic [15:0] pix16;

  assign pix16 = 16'(pixel_in);

  // The sum restarts whenever index 0 is written. This covers both
  // pixel_first and a plain wrap into a new image, so the value always covers
  // exactly the pixels of the image being built.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      checksum_q <= '0;
    end else if (pix_hs) begin
      checksum_q <= (wr_idx == '0) ? pix16 : checksum_q + pix16;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_image_loader.sv
module tb_image_loader;
  localparam int PW = 9;
  localparam int NB = 784;
  localparam int NS = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;

  logic [PW-1:0]            b_pix;
  logic                     b_first, b_valid, b_iready, b_pr, b_iv;
  logic [0:NB-1][PW-1:0]    b_image;
  logic [$clog2(NB)-1:0]    b_cnt;

  logic [PW-1:0]            s_pix;
  logic                     s_first, s_valid, s_iready, s_pr, s_iv;
  logic [0:NS-1][PW-1:0]    s_image;
  logic [$clog2(NS)-1:0]    s_cnt;

`ifdef IMAGE_LOADER_CHECKSUM_EN
  logic [15:0] b_csum, s_csum;
`endif

  image_loader #(.PIXEL_WIDTH(PW), .NUM_PIXELS(NB)) dut_big (
    .clock(clock), .reset(reset), .pixel_in(b_pix), .pixel_first(b_first),
    .pixel_valid(b_valid), .pixel_ready(b_pr), .image(b_image),
    .image_valid(b_iv), .image_ready(b_iready), .pixel_count(b_cnt)
`ifdef IMAGE_LOADER_CHECKSUM_EN
    , .checksum(b_csum)
`endif
  );

  image_loader #(.PIXEL_WIDTH(PW), .NUM_PIXELS(NS)) dut_small (
    .clock(clock), .reset(reset), .pixel_in(s_pix), .pixel_first(s_first),
    .pixel_valid(s_valid), .pixel_ready(s_pr), .image(s_image),
    .image_valid(s_iv), .image_ready(s_iready), .pixel_count(s_cnt)
`ifdef IMAGE_LOADER_CHECKSUM_EN
    , .checksum(s_csum)
`endif
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        v;
    logic        f;
    logic [8:0]  p;
    logic        ir;
    logic        epr;
    logic        eiv;
    logic [1:0]  ecnt;
    logic        cimg;
    logic [35:0] eimg;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic f, input logic [8:0] p,
                              input logic ir, input logic epr, input logic eiv,
                              input logic [1:0] ecnt, input logic cimg,
                              input logic [35:0] eimg);
    vec_t r;
    r.v = v; r.f = f; r.p = p; r.ir = ir; r.epr = epr; r.eiv = eiv;
    r.ecnt = ecnt; r.cimg = cimg; r.eimg = eimg;
    return r;
  endfunction

  function automatic logic [35:0] pk(input logic [8:0] a, input logic [8:0] b,
                                     input logic [8:0] c, input logic [8:0] d);
    return {a, b, c, d};
  endfunction

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Behavioural model of the small loader, written from the pixel/image rules.
  logic [8:0] m_mem [NS];
  int         m_next;
  bit         m_full;

  function automatic logic [35:0] m_image();
    return {m_mem[0], m_mem[1], m_mem[2], m_mem[3]};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t                  tbl [15];
    logic [0:NB-1][PW-1:0] exp_big;
    logic [0:NB-1][PW-1:0] zero_big;
    logic [15:0]           big_sum;

    b_pix = '0; b_first = 0; b_valid = 0; b_iready = 0;
    s_pix = '0; s_first = 0; s_valid = 0; s_iready = 0;
    zero_big = '0;
    big_sum  = '0;

    tbl[0]  = mk(1, 0, 9'h011, 0, 1, 0, 2'd1, 1, pk(9'h011, 0, 0, 0));
    tbl[1]  = mk(1, 0, 9'h022, 0, 1, 0, 2'd2, 1, pk(9'h011, 9'h022, 0, 0));
    tbl[2]  = mk(1, 1, 9'h033, 0, 1, 0, 2'd1, 1, pk(9'h033, 9'h022, 0, 0));
    tbl[3]  = mk(1, 0, 9'h044, 0, 1, 0, 2'd2, 0, '0);
    tbl[4]  = mk(1, 0, 9'h055, 0, 1, 0, 2'd3, 0, '0);
    tbl[5]  = mk(1, 0, 9'h066, 0, 0, 1, 2'd0, 1, pk(9'h033, 9'h044, 9'h055, 9'h066));
    tbl[6]  = mk(1, 1, 9'h077, 1, 1, 0, 2'd0, 1, pk(9'h033, 9'h044, 9'h055, 9'h066));
    tbl[7]  = mk(1, 0, 9'h0A1, 0, 1, 0, 2'd1, 0, '0);
    tbl[8]  = mk(0, 0, 9'h0B1, 0, 1, 0, 2'd1, 0, '0);
    tbl[9]  = mk(1, 0, 9'h0A2, 0, 1, 0, 2'd2, 0, '0);
    tbl[10] = mk(0, 1, 9'h0B2, 0, 1, 0, 2'd2, 0, '0);
    tbl[11] = mk(1, 0, 9'h0A3, 0, 1, 0, 2'd3, 0, '0);
    tbl[12] = mk(0, 0, 9'h0B3, 0, 1, 0, 2'd3, 1, pk(9'h0A1, 9'h0A2, 9'h0A3, 9'h066));
    tbl[13] = mk(1, 0, 9'h0A4, 0, 0, 1, 2'd0, 1, pk(9'h0A1, 9'h0A2, 9'h0A3, 9'h0A4));
    tbl[14] = mk(1, 1, 9'h0C5, 0, 0, 1, 2'd0, 1, pk(9'h0A1, 9'h0A2, 9'h0A3, 9'h0A4));

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_s_cnt", 64'(s_cnt), 64'(0));
    chk("rst_s_iv", 64'(s_iv), 64'(0));
    chk("rst_s_img", 64'(s_image), 64'(0));
    chk("rst_b_img", 64'(b_image == zero_big), 64'(1));
    reset = 1'b1;
    @(negedge clock);
    chk("rst_s_pr", 64'(s_pr), 64'(1));
    chk("rst_b_pr", 64'(b_pr), 64'(1));
    chk("rst_b_cnt", 64'(b_cnt), 64'(0));

    // Table-driven resync / gap sequences on the 4-pixel loader
    for (int i = 0; i < 15; i++) begin
      s_valid = tbl[i].v; s_first = tbl[i].f; s_pix = tbl[i].p; s_iready = tbl[i].ir;
      cyc();
      chk($sformatf("tbl%0d_pr", i), 64'(s_pr), 64'(tbl[i].epr));
      chk($sformatf("tbl%0d_iv", i), 64'(s_iv), 64'(tbl[i].eiv));
      chk($sformatf("tbl%0d_cnt", i), 64'(s_cnt), 64'(tbl[i].ecnt));
      if (tbl[i].cimg)
        chk($sformatf("tbl%0d_img", i), 64'(s_image), 64'(tbl[i].eimg));
    end
    s_valid = 0; s_first = 0; s_iready = 0;

    // Full 784-pixel load on consecutive cycles
    for (int i = 0; i < NB; i++) begin
      exp_big[i] = PW'(i % 512);
      big_sum    = big_sum + 16'(i % 512);
    end
    for (int i = 0; i < NB; i++) begin
      if (i == NB - 1) begin
        chk("big_iv_before_last", 64'(b_iv), 64'(0));
        chk("big_cnt_before_last", 64'(b_cnt), 64'(NB - 1));
      end
      b_valid = 1; b_first = 0; b_pix = PW'(i % 512);
      cyc();
    end
    b_valid = 0;
    chk("big_iv", 64'(b_iv), 64'(1));
    chk("big_pr", 64'(b_pr), 64'(0));
    chk("big_cnt", 64'(b_cnt), 64'(0));
    chk("big_img", 64'(b_image == exp_big), 64'(1));
`ifdef IMAGE_LOADER_CHECKSUM_EN
    chk("big_csum", 64'(b_csum), 64'(big_sum));
`endif

    // Backpressure: pixels offered while FULL must be ignored
    for (int i = 0; i < 10; i++) begin
      b_valid = 1; b_first = 1'($urandom_range(0, 1)); b_pix = PW'($urandom_range(0, 511));
      cyc();
      chk($sformatf("bp%0d_img", i), 64'(b_image == exp_big), 64'(1));
      chk($sformatf("bp%0d_iv_pr_cnt", i), 64'({b_iv, b_pr, b_cnt}), 64'({1'b1, 1'b0, 10'd0}));
    end
    b_iready = 1; b_valid = 1; b_first = 1; b_pix = 9'h005;
    cyc();
    b_iready = 0; b_valid = 0; b_first = 0;
    chk("bp_release_pr", 64'(b_pr), 64'(1));
    chk("bp_release_iv", 64'(b_iv), 64'(0));
    chk("bp_release_cnt", 64'(b_cnt), 64'(0));
    chk("bp_release_img", 64'(b_image == exp_big), 64'(1));
    b_valid = 1; b_pix = 9'h1FF;
    cyc();
    b_valid = 0;
    exp_big[0] = 9'h1FF;
    chk("big_reload_img", 64'(b_image == exp_big), 64'(1));
    chk("big_reload_cnt", 64'(b_cnt), 64'(1));

    // Reset in the middle of an image
    s_iready = 1;
    cyc();
    s_iready = 0;
    s_valid = 1; s_pix = 9'h00A;
    cyc();
    s_pix = 9'h00B;
    cyc();
    s_valid = 0;
    chk("mid_cnt_pre", 64'(s_cnt), 64'(2));
    reset = 1'b0;
    #1;
    chk("mid_rst_cnt", 64'(s_cnt), 64'(0));
    chk("mid_rst_img", 64'(s_image), 64'(0));
    chk("mid_rst_iv", 64'(s_iv), 64'(0));
    chk("mid_rst_b_cnt", 64'(b_cnt), 64'(0));
    chk("mid_rst_b_img", 64'(b_image == zero_big), 64'(1));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_pr", 64'(s_pr), 64'(1));

    // Randomized traffic against the behavioural model
    for (int k = 0; k < NS; k++) m_mem[k] = '0;
    m_next = 0;
    m_full = 0;
    for (int c = 0; c < 1500; c++) begin
      int k;
      s_valid  = ($urandom_range(0, 3) != 0);
      s_first  = ($urandom_range(0, 9) == 0);
      s_pix    = 9'($urandom_range(0, 511));
      s_iready = ($urandom_range(0, 2) == 0);
      if (!m_full) begin
        if (s_valid) begin
          k = s_first ? 0 : m_next;
          m_mem[k] = s_pix;
          m_next = k + 1;
          if (m_next == NS) begin
            m_next = 0;
            m_full = 1;
          end
        end
      end else if (s_iready) begin
        m_full = 0;
      end
      cyc();
      chk("rnd_pr", 64'(s_pr), 64'(!m_full));
      chk("rnd_iv", 64'(s_iv), 64'(m_full));
      chk("rnd_cnt", 64'(s_cnt), 64'(m_next));
      chk("rnd_img", 64'(s_image), 64'(m_image()));
`ifdef IMAGE_LOADER_CHECKSUM_EN
      if (m_full)
        chk("rnd_csum", 64'(s_csum), 64'(16'(m_mem[0] + m_mem[1] + m_mem[2] + m_mem[3])));
`endif
    end
    s_valid = 0; s_first = 0;
    s_iready = 1;
    cyc();
    s_iready = 0;

`ifdef IMAGE_LOADER_CHECKSUM_EN
    // Checksum of four maximal pixels
    for (int i = 0; i < NS; i++) begin
      s_valid = 1; s_first = (i == 0); s_pix = 9'h1FF;
      cyc();
    end
    s_valid = 0; s_first = 0;
    chk("csum_iv", 64'(s_iv), 64'(1));
    chk("csum_val", 64'(s_csum), 64'(16'h07FC));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 9, bits per pixel.
REQ-002 SHALL have parameter NUM_PIXELS, default 784, pixels per image (legal range 2 or more).
REQ-003 SHALL have port clock, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port pixel_in, input, PIXEL_WIDTH, incoming pixel value.
REQ-006 SHALL have port pixel_first, input, 1, marks pixel_in as pixel 0 of an image.
REQ-007 SHALL have port pixel_valid, input, 1, pixel_in/pixel_first valid.
REQ-008 SHALL have port pixel_ready, output, 1, loader accepts a pixel this cycle.
REQ-009 SHALL have port image, output, NUM_PIXELS x PIXEL_WIDTH packed as [0:NUM_PIXELS-1][PIXEL_WIDTH-1:0], assembled image; element 0 is first pixel.
REQ-010 SHALL have port image_valid, output, 1, image holds a complete image.
REQ-011 SHALL have port image_ready, input, 1, consumer takes image.
REQ-012 SHALL have port pixel_count, output, $clog2(NUM_PIXELS), index of the next pixel to be written.

Function
REQ-013 SHALL implement two states: LOAD (pixel_ready=1, image_valid=0) and FULL (pixel_ready=0, image_valid=1).
REQ-014 SHALL define a pixel handshake as pixel_valid AND pixel_ready on a rising edge, and an image handshake as image_valid AND image_ready.
REQ-015 SHALL, on a pixel handshake with pixel_first=0, write pixel_in to image[pixel_count] and increment pixel_count by 1.
REQ-016 SHALL, on a pixel handshake with pixel_first=1, discard any partial image, write pixel_in to image[0] and set pixel_count to 1.
REQ-017 SHALL, when the handshaken pixel is written at index NUM_PIXELS-1, wrap pixel_count to 0 and enter FULL on the same edge, so image_valid rises one cycle after the last pixel.
REQ-018 SHALL hold image, pixel_count and image_valid stable in FULL until the image handshake.
REQ-019 SHALL, on the image handshake, return to LOAD on that edge; pixel_ready=1 the next cycle (one-cycle bubble; no pixel accepted in the handshake cycle).
REQ-020 SHALL ignore pixel_in/pixel_first whenever no pixel handshake occurs.
REQ-021 SHALL NOT clear image contents on the return to LOAD; unwritten elements keep prior values until overwritten.
REQ-022 SHALL drive pixel_ready and image_valid directly from the state register (no combinational path from inputs).

Reset
REQ-023 SHALL, on reset low, immediately enter LOAD, set pixel_count=0 and image_valid=0, clear image to all zeros, and set pixel_ready=1 after reset deasserts.
REQ-024 SHALL, on reset asserted mid-image or in FULL, discard the partial or pending image with no handshake completed.

Configuration
REQ-025 SHALL, with macro IMAGE_LOADER_CHECKSUM_EN defined, add output checksum (16 bits) holding the modulo-2^16 sum of the NUM_PIXELS pixels of the current image, valid whenever image_valid=1.
REQ-026 SHALL update checksum incrementally per pixel handshake, restart it from pixel_in on pixel_first=1, and reset it to 0.
REQ-027 SHALL, without IMAGE_LOADER_CHECKSUM_EN, have no checksum port or logic, with all other behaviour identical.

Verification
REQ-028 SHALL cover a full load: NUM_PIXELS=784, pixels i mod 512 on consecutive cycles, image_ready=0 -> image_valid=1 one cycle after pixel 783, image[k]=k mod 512, pixel_count=0, pixel_ready=0.
REQ-029 SHALL cover backpressure: in FULL, pixel_valid=1 for 10 cycles with image_ready=0 -> image unchanged; after an image_ready pulse, pixel_ready=1 on the next cycle and image_valid=0.
REQ-030 SHALL cover resync: NUM_PIXELS=4; send 0x11,0x22 then 0x33 with pixel_first=1, then 0x44,0x55,0x66 -> image = {0x33,0x44,0x55,0x66}.
REQ-031 SHALL cover gaps: NUM_PIXELS=4 with pixel_valid toggling 1,0,1,0 -> only the valid cycles are stored; image_valid is asserted after the 4th accepted pixel.
REQ-032 SHALL cover reset mid-image: reset low after 2 of 4 pixels -> pixel_count=0, image all zero, image_valid=0, immediately.
REQ-033 SHALL cover the checksum (macro defined): NUM_PIXELS=4, pixels 511,511,511,511 -> checksum=0x07FC at image_valid.
